// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path: widths, reset values and the
// fetch FSM state encoding.
package mips_pkg;

  localparam int DW = 32;
  localparam int AW = 32;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_pc_next.sv
// Combinational next-PC selection: jump beats taken branch, which beats
// sequential pc + 4.
module pc_next
  import mips_pkg::*;
#(
  parameter int AW_P = AW
) (
  input  logic [AW_P-1:0] pc_i,
  input  logic            jump_i,
  input  logic [25:0]     jump_index_i,
  input  logic            branch_taken_i,
  input  logic [AW_P-1:0] branch_offset_i,
  output logic [AW_P-1:0] pc_plus4_o,
  output logic [AW_P-1:0] next_pc_o
);

  logic [AW_P-1:0] jumpTarget;
  logic [AW_P-1:0] branchTarget;

  assign pc_plus4_o = pc_i + AW_P'(4);

  // Jumps stay inside the 256 MB region of the delay-slot address.
  assign jumpTarget   = {pc_plus4_o[AW_P-1:28], jump_index_i, 2'b00};
  assign branchTarget = pc_plus4_o + (branch_offset_i << 2);

  always_comb begin
    next_pc_o = pc_plus4_o;
    if (jump_i) begin
      next_pc_o = jumpTarget;
    end else if (branch_taken_i) begin
      next_pc_o = branchTarget;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC and instruction register and runs the
// BOOT -> FETCH -> VALID handshake with instruction memory.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int          DW       = mips_pkg::DW,
  parameter int          AW       = mips_pkg::AW,
  parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_rdata,
  input  logic          imem_ack,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_offset,
  input  logic          jump,
  input  logic [25:0]   jump_index,
  output logic [DW-1:0] instr,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc_plus4,
  output logic [15:0]   imm16
);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [AW-1:0] nextPc;

  pc_next #(.AW_P(AW)) u_pc_next (
    .pc_i            (pc_q),
    .jump_i          (jump),
    .jump_index_i    (jump_index),
    .branch_taken_i  (branch_taken),
    .branch_offset_i (branch_offset),
    .pc_plus4_o      (pc_plus4),
    .next_pc_o       (nextPc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= DW'(NOP_INSTR);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Control inputs only matter in VALID; ack only matters in FETCH.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = VALID;
        end
      end
      VALID: begin
        if (!stall) begin
          pc_d    = nextPc;
          state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == VALID);
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign imm16       = instr_q[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a small
// variable-latency instruction memory driven from the stimulus tasks.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [15:0] imm16;

  int checkCount = 0;
  int failCount  = 0;

  instr_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ack      (imem_ack),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .imm16         (imm16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic setControls(input logic j, input logic [25:0] idx,
                             input logic br, input logic [31:0] off);
    jump          = j;
    jump_index    = idx;
    branch_taken  = br;
    branch_offset = off;
  endtask

  // Waits for a request, checks the address stays put for latency cycles,
  // acks with data and checks the instruction register afterwards.
  task automatic applyStimulus(input string tag, input logic [31:0] expAddr,
                               input int latency, input logic [31:0] data);
    int n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      checkOutput({tag, "_reqTimeout"}, 32'(imem_req), 32'd1);
      return;
    end
    checkOutput({tag, "_addr"}, imem_addr, expAddr);
    for (int i = 1; i < latency; i++) begin
      @(negedge clk);
      checkOutput({tag, "_reqHeld"}, 32'(imem_req), 32'd1);
      checkOutput({tag, "_addrHeld"}, imem_addr, expAddr);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    checkOutput({tag, "_instr"}, instr, data);
    checkOutput({tag, "_valid"}, 32'(instr_valid), 32'd1);
    checkOutput({tag, "_pc"}, pc, expAddr);
    checkOutput({tag, "_reqLow"}, 32'(imem_req), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    stall      = 1'b0;
    setControls(1'b0, 26'h0, 1'b0, 32'h0);

    // Reset values, then BOOT holds the request low for one cycle.
    repeat (2) @(negedge clk);
    checkOutput("rstPc", pc, 32'h0);
    checkOutput("rstInstr", instr, 32'h0);
    checkOutput("rstValid", 32'(instr_valid), 32'd0);
    checkOutput("rstReq", 32'(imem_req), 32'd0);
    checkOutput("rstImm16", 32'(imm16), 32'h0);
    rst_n = 1'b1;
    checkOutput("bootReq", 32'(imem_req), 32'd0);
    @(negedge clk);
    checkOutput("firstReq", 32'(imem_req), 32'd1);
    applyStimulus("zeroWait", 32'h0, 1, 32'h2008_0005);
    checkOutput("imm16", 32'(imm16), 32'h0000_0005);
    checkOutput("pcPlus4", pc_plus4, 32'h4);

    // Sequential fetches with a three-cycle memory.
    applyStimulus("seq4", 32'h4, 3, 32'h1111_0004);
    applyStimulus("seq8", 32'h8, 3, 32'h2222_0008);

    // Jump to 0x100, then backward and forward branches.
    setControls(1'b1, 26'h40, 1'b0, 32'h0);
    applyStimulus("jmp100", 32'h100, 1, 32'h3333_0100);
    setControls(1'b0, 26'h0, 1'b1, 32'hFFFF_FFFE);
    applyStimulus("brBack", 32'h0FC, 2, 32'h4444_00FC);
    setControls(1'b1, 26'h40, 1'b0, 32'h0);
    applyStimulus("jmpBack", 32'h100, 1, 32'h5555_0100);
    setControls(1'b0, 26'h0, 1'b1, 32'h0000_0003);
    applyStimulus("brFwd", 32'h110, 1, 32'h6666_0110);
    setControls(1'b0, 26'h0, 1'b1, 32'hFFFF_FFFF);
    applyStimulus("selfLoop", 32'h110, 1, 32'h7777_0110);

    // Reach 0x1000_0000, then jump and branch together: jump wins.
    setControls(1'b0, 26'h0, 1'b1, 32'h03FF_FFBB);
    applyStimulus("brFar", 32'h1000_0000, 1, 32'h8888_0000);
    setControls(1'b1, 26'h40, 1'b1, 32'h0000_0010);
    applyStimulus("jmpWins", 32'h1000_0100, 1, 32'h9999_0100);

    // Stall with branch toggling; release with no branch.
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      setControls(1'b0, 26'h0, (i % 2) == 0, 32'h0000_0008);
      @(negedge clk);
      checkOutput("stallPc", pc, 32'h1000_0100);
      checkOutput("stallInstr", instr, 32'h9999_0100);
      checkOutput("stallReq", 32'(imem_req), 32'd0);
      checkOutput("stallValid", 32'(instr_valid), 32'd1);
    end
    stall = 1'b0;
    setControls(1'b0, 26'h0, 1'b0, 32'h0000_0008);
    applyStimulus("stallRel", 32'h1000_0104, 1, 32'hAAAA_0104);

    // Wrap from the top of the address space.
    setControls(1'b0, 26'h0, 1'b1, 32'h3BFF_FFBD);
    applyStimulus("toTop", 32'hFFFF_FFFC, 1, 32'hBBBB_FFFC);
    setControls(1'b0, 26'h0, 1'b0, 32'h0);
    applyStimulus("wrap", 32'h0, 1, 32'hCCCC_0000);

    // Reset in the middle of a fetch, with an ack arriving late.
    @(negedge clk);
    checkOutput("midReq", 32'(imem_req), 32'd1);
    checkOutput("midAddr", imem_addr, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncReq", 32'(imem_req), 32'd0);
    checkOutput("asyncPc", pc, 32'h0);
    checkOutput("asyncValid", 32'(instr_valid), 32'd0);
    checkOutput("asyncInstr", instr, 32'h0);
    @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = 32'hFEED_FACE;
    rst_n      = 1'b1;
    @(negedge clk);
    imem_ack   = 1'b0;
    checkOutput("lateAckInstr", instr, 32'h0);
    checkOutput("lateAckValid", 32'(instr_valid), 32'd0);
    checkOutput("lateAckReq", 32'(imem_req), 32'd1);
    applyStimulus("afterRst", 32'h0, 2, 32'hDDDD_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
